// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer and the ALU decoder.
// The optional zero-operand multiply bypass is enabled with MULDIV_ZERO_BYPASS_EN.
package muldiv_seq_pkg;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    // Must match the codes produced by the main ALU decoder.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_seq_alu.sv
// Core ALU (AND/OR/ADD/SUB), shared by the execute stage and the mul/div sequencer.
module alu
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      ALUControl,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    always_comb begin
        result = '0;
        case (ALUControl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/MULHU/DIVU/REMU sequencer: one bit per clock through a shared ALU.
// Define MULDIV_ZERO_BYPASS_EN to finish multiplies with a zero operand in one cycle.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [5:0] LAST_STEP = 6'(XLEN - 1);

    state_t          state, state_n;
    logic [1:0]      op_r;
    logic [XLEN-1:0] hi, lo, mcand;
    logic [5:0]      count;
    logic [XLEN-1:0] alu_a, alu_b, alu_res;
    logic [3:0]      alu_ctl;
    logic            alu_zero_unused;
    logic [XLEN-1:0] rshift, sum, hi_step, lo_step, short_res;
    logic            carry, take, accept, shortcut, last;

    // hi/lo double as rem/quo for divides; mcand doubles as the divisor.
    alu #(.XLEN(XLEN)) u_alu (
        .a          (alu_a),
        .b          (alu_b),
        .ALUControl (alu_ctl),
        .result     (alu_res),
        .zero       (alu_zero_unused)
    );

    assign accept = start && (state != S_RUN);
    assign busy   = (state == S_RUN) || accept;
    assign done   = (state == S_DONE);
    assign last   = (count == LAST_STEP);

    always_comb begin
        rshift  = {hi[XLEN-2:0], lo[XLEN-1]};
        alu_a   = '0;
        alu_b   = '0;
        alu_ctl = ALU_ADD;
        if (state == S_RUN) begin
            alu_b = mcand;
            if (op_r[1]) begin
                alu_a   = rshift;
                alu_ctl = ALU_SUB;
            end else begin
                alu_a = hi;
            end
        end
    end

    always_comb begin
        sum   = lo[0] ? alu_res : hi;
        carry = lo[0] & (alu_res < hi);
        take  = hi[XLEN-1] | (rshift >= mcand);
        if (op_r[1]) begin
            hi_step = take ? alu_res : rshift;
            lo_step = {lo[XLEN-2:0], take};
        end else begin
            hi_step = {carry, sum[XLEN-1:1]};
            lo_step = {sum[0], lo[XLEN-1:1]};
        end
    end

    // Operations whose answer is known at issue skip the RUN phase.
    always_comb begin
        shortcut  = 1'b0;
        short_res = '0;
        if (op[1] && (rs2_val == '0)) begin
            shortcut  = 1'b1;
            short_res = (op == OP_DIVU) ? '1 : rs1_val;
        end
`ifdef MULDIV_ZERO_BYPASS_EN
        else if (!op[1] && ((rs1_val == '0) || (rs2_val == '0))) begin
            shortcut  = 1'b1;
            short_res = '0;
        end
`endif
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: state_n = start ? (shortcut ? S_DONE : S_RUN) : S_IDLE;
            S_RUN:          state_n = last ? S_DONE : S_RUN;
            default:        state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_r   <= '0;
            hi     <= '0;
            lo     <= '0;
            mcand  <= '0;
            count  <= '0;
            result <= '0;
        end else if (accept) begin
            op_r  <= op;
            count <= '0;
            hi    <= '0;
            lo    <= op[1] ? rs1_val : rs2_val;
            mcand <= op[1] ? rs2_val : rs1_val;
            if (shortcut) result <= short_res;
        end else if (state == S_RUN) begin
            hi    <= hi_step;
            lo    <= lo_step;
            count <= count + 6'd1;
            if (last) begin
                case (op_r)
                    OP_MUL:   result <= lo_step;
                    OP_MULHU: result <= hi_step;
                    OP_DIVU:  result <= lo_step;
                    default:  result <= hi_step;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised self-checking bench for muldiv_seq against a plain-arithmetic model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [31:0] rs1_val, rs2_val, result;
    logic        busy, done;

    int checks = 0;
    int failures = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[1] && b == 0) return 1;
`ifdef MULDIV_ZERO_BYPASS_EN
        if (!o[1] && (a == 0 || b == 0)) return 1;
`endif
        return 33;
    endfunction

    // Issues one op (at the next falling edge if sync, else right now in a DONE cycle)
    // and returns during the done cycle. inject_at>0 pulses a stray start in that RUN cycle.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit sync, input int inject_at);
        int          lat;
        bit          busy_bad;
        logic [31:0] exp;
        int          exp_lat;
        exp     = model(o, a, b);
        exp_lat = model_lat(o, a, b);
        if (sync) @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs1_val = a;
        rs2_val = b;
        #1;
        check({tag, ".busy_issue"}, 32'(busy), 32'd1);
        if (!sync) check({tag, ".done_b2b"}, 32'(done), 32'd1);
        busy_bad = 1'b0;
        for (lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            start = (lat == inject_at);
            if (start) begin
                op      = ~o;
                rs1_val = $urandom;
                rs2_val = $urandom;
            end
            #1;
            if (done) break;
            if (!busy) busy_bad = 1'b1;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".result"}, result, exp);
        check({tag, ".busy_done"}, 32'(busy), 32'd0);
        check({tag, ".busy_run"}, 32'(busy_bad), 32'd0);
    endtask

    initial begin
        bit          seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'd0;
        rs1_val = '0;
        rs2_val = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.result", result, 32'd0);
        reset = 1'b0;

        do_op("mul_7x6", 2'd0, 32'd7, 32'd6, 1'b1, 0);
        do_op("mulhu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        do_op("mul_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        do_op("divu_100_7", 2'd2, 32'd100, 32'd7, 1'b1, 0);
        do_op("remu_100_7", 2'd3, 32'd100, 32'd7, 1'b1, 0);
        do_op("divu_ff_1", 2'd2, 32'hFFFF_FFFF, 32'd1, 1'b1, 0);
        do_op("divu_5_0", 2'd2, 32'd5, 32'd0, 1'b1, 0);
        do_op("remu_5_0", 2'd3, 32'd5, 32'd0, 1'b1, 0);
        do_op("mul_inject", 2'd0, 32'h0001_2345, 32'h0006_789A, 1'b1, 12);
        do_op("b2b_first", 2'd2, 32'd1000, 32'd7, 1'b1, 0);
        do_op("b2b_second", 2'd3, 32'd1000, 32'd7, 1'b0, 0);
        do_op("mul_0x9", 2'd0, 32'd0, 32'd9, 1'b1, 0);
        do_op("remu_big", 2'd3, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1, 0);

        // Reset ten cycles into a divide discards it without a done pulse.
        @(negedge clk);
        start   = 1'b1;
        op      = 2'd2;
        rs1_val = 32'd12345;
        rs2_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset.busy", 32'(busy), 32'd0);
        check("midreset.done", 32'(done), 32'd0);
        check("midreset.result", result, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("midreset.quiet", 32'(seen), 32'd0);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       ra = 32'd0;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) rb = $urandom >> $urandom_range(0, 31);
            do_op($sformatf("rand%0d", i), ro, ra, rb, ($urandom_range(0, 3) != 0), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
